pinky_writeback: RTL and testbench
==================================

// Module: pinky_writeback
// PURPOSE
//  Final (writeback) stage of the 4-stage PinKY pipeline. Consumes the ALU/memory result, IR and PC from the execute stage.
//  Commits register writes, updates the Z flag used by fetch for NE/EQ nullification, and redirects/flushes on writes to R15.
//  Latches halt on SYS. Sits downstream of the execute stage; outputs feed the stage-1 register file and stage-0 fetch.
// PARAMETERS
//  FLUSH_DEPTH  3   younger in-flight instructions squashed after a PC redirect (1..7)
//  CNT_W        16  width of retire counter
// PORTS
//  clk           in   1      rising-edge clock
//  reset         in   1      synchronous, active-low reset
//  ir_in         in   16     instruction from execute stage
//  result        in   16     execute-stage value for ir_in
//  pc            in   16     PC of ir_in
//  rf_we         out  1      register-file write enable (one-cycle pulse per commit)
//  rf_addr       out  4      destination register (ir_in[7:4])
//  rf_data       out  16     write data
//  z_out         out  1      Z flag to fetch
//  pc_load       out  1      one-cycle pulse: fetch loads pc_target
//  pc_target     out  16     redirect address
//  squash        out  1      high while younger instructions are being discarded
//  halt          out  1      sticky halt
//  pc_follow     out  16     PC of last committed instruction
//  retire_count  out  CNT_W  committed instruction count
// BEHAVIOUR
//  - All outputs registered; a committed instruction's effects appear one cycle after sampling.
//  - Reset (reset==0 at posedge): every output 0, state RUN, flush counter 0; overrides everything, including mid-flush.
//  - Writer opcodes: ADD ADDF AND BIC EOR FTOI ITOF LDR MOV MUL MULF NEG ORR RECF SHA SLT SUB SUBF.
//  - Non-writers: STR, SYS, NOP (0x14), PRE (0x18-0x1F, ir[15:14]==11), undefined 0x15-0x17.
//  - Bubble: NOP, PRE or undefined opcode; never retired; never touch Z.
//  - States:
//    RUN:
//     - writer: rf_we<=1, rf_addr<=ir[7:4], rf_data<=result.
//     - non-bubble: pc_follow<=pc, retire_count+=1, wraps 2^CNT_W-1 -> 0.
//     - non-bubble with CC==S (ir[10:9]==01), STR included: z_out<=(result==0). Other CC: Z holds.
//     - writer with rd==15: additionally pc_load<=1, pc_target<=result, squash<=1, cnt<=FLUSH_DEPTH, go FLUSH.
//     - SYS: retired, halt<=1, go HALTED; no write.
//    FLUSH:
//     - each cycle discard ir_in: no write, no Z, no halt, no retire; cnt-=1.
//     - leave at cnt==1 -> RUN with squash<=0. pc_load pulses only on the entry cycle.
//    HALTED:
//     - all inputs ignored; rf_we=0, pc_load=0; halt, z_out, counters hold. Exit only by reset.
//  - rf_we/pc_load drop to 0 on any cycle without a new commit/redirect.
//  - Simultaneous events: rd==15 with CC==S updates Z and redirects in the same cycle.
//  - SYS or rd==15 arriving during FLUSH is discarded.
// CONFIGURATION
//  WB_FORWARD_EN defined: adds outputs fwd_valid(1), fwd_addr(4), fwd_data(16).
//   - Combinational view of the write that commits at the next edge.
//   - fwd_valid = RUN && writer && reset==1.
//  WB_FORWARD_EN undefined: ports absent, no bypass logic; behaviour otherwise identical.
// TESTING
//  1 reset low 1 clk -> all outputs 0; then ADD rd=3 result=0x1234 CC=AL
//    -> next cycle rf_we=1 rf_addr=3 rf_data=0x1234, z_out=0, retire_count=1.
//  2 SUB CC=S result=0 -> z_out=1; MOV CC=S result=5 -> z_out=0; ADD CC=AL result=0 -> z_out holds.
//  3 MOV rd=15 result=0x0040, then 3 writers -> pc_load=1 one cycle, pc_target=0x0040, squash 3 cycles,
//    no rf_we for the 3; 4th writer commits.
//  4 SYS (op 0x13) -> halt=1 next cycle; subsequent ADD produces no rf_we, retire_count frozen;
//    reset low -> halt=0.
//  5 NOP, PRE, STR CC=S result=0 -> only STR retires (count+1) and sets z_out=1; no rf_we for any.
//  6 preload retire_count to 0xFFFF via 65535 commits, one more -> 0x0000;
//    with WB_FORWARD_EN, fwd_* match rf_* one cycle early.

Source files
------------

// File: rtl/pinky_writeback.sv
// PinKY writeback stage: commits register writes, maintains the Z flag,
// redirects fetch on writes to R15 and squashes the younger instructions
// that follow, and latches halt on SYS.
// Optional macro WB_FORWARD_EN adds a combinational bypass (fwd_*) showing
// the write that will commit at the next clock edge.
//
// Instruction fields: op = ir[15:11], cc = ir[10:9], rd = ir[7:4].
// Opcode map: 0x00-0x12 are writers except STR (0x10); 0x13 is SYS;
// 0x14 is NOP; 0x15-0x17 are undefined; 0x18-0x1F are PRE.
// Bubbles are 0x14 and above.
//
// state   | meaning
// RUN     | normal commit of the incoming instruction
// FLUSH   | discarding younger instructions after a redirect
// HALTED  | SYS seen; inputs ignored until reset
module pinky_writeback #(
  parameter int FLUSH_DEPTH = 3,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [15:0]      i_ir_in,
  input  logic [15:0]      i_result,
  input  logic [15:0]      i_pc,
  output logic             o_rf_we,
  output logic [3:0]       o_rf_addr,
  output logic [15:0]      o_rf_data,
  output logic             o_z_out,
  output logic             o_pc_load,
  output logic [15:0]      o_pc_target,
  output logic             o_squash,
  output logic             o_halt,
  output logic [15:0]      o_pc_follow,
  output logic [CNT_W-1:0] o_retire_count
`ifdef WB_FORWARD_EN
  ,
  output logic             o_fwd_valid,
  output logic [3:0]       o_fwd_addr,
  output logic [15:0]      o_fwd_data
`endif
);

  localparam logic [4:0] OP_STR = 5'h10;
  localparam logic [4:0] OP_SYS = 5'h13;
  localparam logic [4:0] OP_NOP = 5'h14;
  localparam logic [1:0] CC_S   = 2'b01;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t             r_state, w_nxt_state;
  logic [2:0]         r_cnt, w_nxt_cnt;
  logic               r_rf_we, w_nxt_rf_we;
  logic [3:0]         r_rf_addr, w_nxt_rf_addr;
  logic [15:0]        r_rf_data, w_nxt_rf_data;
  logic               r_z, w_nxt_z;
  logic               r_pc_load, w_nxt_pc_load;
  logic [15:0]        r_pc_target, w_nxt_pc_target;
  logic               r_squash, w_nxt_squash;
  logic               r_halt, w_nxt_halt;
  logic [15:0]        r_pc_follow, w_nxt_pc_follow;
  logic [CNT_W-1:0]   r_retire, w_nxt_retire;

  logic [4:0] w_op;
  logic [1:0] w_cc;
  logic [3:0] w_rd;
  logic       w_bubble;
  logic       w_writer;
  logic       w_is_sys;
  logic       w_unused_ir;

  assign w_op        = i_ir_in[15:11];
  assign w_cc        = i_ir_in[10:9];
  assign w_rd        = i_ir_in[7:4];
  assign w_bubble    = (w_op >= OP_NOP);
  assign w_writer    = (w_op < OP_SYS) && (w_op != OP_STR);
  assign w_is_sys    = (w_op == OP_SYS);
  assign w_unused_ir = ^{i_ir_in[8], i_ir_in[3:0]};

  // Next-state and next-output decode; every register holds unless changed.
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_cnt       = r_cnt;
    w_nxt_rf_we     = 1'b0;
    w_nxt_rf_addr   = r_rf_addr;
    w_nxt_rf_data   = r_rf_data;
    w_nxt_z         = r_z;
    w_nxt_pc_load   = 1'b0;
    w_nxt_pc_target = r_pc_target;
    w_nxt_squash    = r_squash;
    w_nxt_halt      = r_halt;
    w_nxt_pc_follow = r_pc_follow;
    w_nxt_retire    = r_retire;
    case (r_state)
      ST_RUN: begin
        if (!w_bubble) begin
          w_nxt_pc_follow = i_pc;
          w_nxt_retire    = r_retire + CNT_W'(1);
          if (w_cc == CC_S) begin
            w_nxt_z = (i_result == 16'h0000);
          end
          if (w_writer) begin
            w_nxt_rf_we   = 1'b1;
            w_nxt_rf_addr = w_rd;
            w_nxt_rf_data = i_result;
            if (w_rd == 4'hF) begin
              w_nxt_pc_load   = 1'b1;
              w_nxt_pc_target = i_result;
              w_nxt_squash    = 1'b1;
              w_nxt_cnt       = 3'(FLUSH_DEPTH);
              w_nxt_state     = ST_FLUSH;
            end
          end
          if (w_is_sys) begin
            w_nxt_halt  = 1'b1;
            w_nxt_state = ST_HALTED;
          end
        end
      end
      ST_FLUSH: begin
        w_nxt_cnt = r_cnt - 3'd1;
        if (r_cnt == 3'd1) begin
          w_nxt_squash = 1'b0;
          w_nxt_state  = ST_RUN;
        end
      end
      ST_HALTED: begin
      end
      default: begin
        w_nxt_state = ST_RUN;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= ST_RUN;
      r_cnt       <= 3'd0;
      r_rf_we     <= 1'b0;
      r_rf_addr   <= 4'h0;
      r_rf_data   <= 16'h0000;
      r_z         <= 1'b0;
      r_pc_load   <= 1'b0;
      r_pc_target <= 16'h0000;
      r_squash    <= 1'b0;
      r_halt      <= 1'b0;
      r_pc_follow <= 16'h0000;
      r_retire    <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_cnt       <= w_nxt_cnt;
      r_rf_we     <= w_nxt_rf_we;
      r_rf_addr   <= w_nxt_rf_addr;
      r_rf_data   <= w_nxt_rf_data;
      r_z         <= w_nxt_z;
      r_pc_load   <= w_nxt_pc_load;
      r_pc_target <= w_nxt_pc_target;
      r_squash    <= w_nxt_squash;
      r_halt      <= w_nxt_halt;
      r_pc_follow <= w_nxt_pc_follow;
      r_retire    <= w_nxt_retire;
    end
  end

  assign o_rf_we        = r_rf_we;
  assign o_rf_addr      = r_rf_addr;
  assign o_rf_data      = r_rf_data;
  assign o_z_out        = r_z;
  assign o_pc_load      = r_pc_load;
  assign o_pc_target    = r_pc_target;
  assign o_squash       = r_squash;
  assign o_halt         = r_halt;
  assign o_pc_follow    = r_pc_follow;
  assign o_retire_count = r_retire;

`ifdef WB_FORWARD_EN
  // Bypass of the write that commits at the coming edge.
  assign o_fwd_valid = (r_state == ST_RUN) && w_writer && i_reset;
  assign o_fwd_addr  = w_rd;
  assign o_fwd_data  = i_result;
`endif

endmodule

// File: tb/tb_pinky_writeback.sv
module tb_pinky_writeback;
  localparam int FLUSH_DEPTH = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] ir_in = 16'h0;
  logic [15:0] result = 16'h0;
  logic [15:0] pc = 16'h0;
  logic        rf_we, z_out, pc_load, squash, halt;
  logic [3:0]  rf_addr;
  logic [15:0] rf_data, pc_target, pc_follow, retire_count;
`ifdef WB_FORWARD_EN
  logic        fwd_valid;
  logic [3:0]  fwd_addr;
  logic [15:0] fwd_data;
`endif

  pinky_writeback #(.FLUSH_DEPTH(FLUSH_DEPTH), .CNT_W(16)) dut (
    .i_clk(clk), .i_reset(reset), .i_ir_in(ir_in), .i_result(result), .i_pc(pc),
    .o_rf_we(rf_we), .o_rf_addr(rf_addr), .o_rf_data(rf_data), .o_z_out(z_out),
    .o_pc_load(pc_load), .o_pc_target(pc_target), .o_squash(squash), .o_halt(halt),
    .o_pc_follow(pc_follow), .o_retire_count(retire_count)
`ifdef WB_FORWARD_EN
    , .o_fwd_valid(fwd_valid), .o_fwd_addr(fwd_addr), .o_fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rf_we;
    logic [3:0]  rf_addr;
    logic [15:0] rf_data;
    logic        z;
    logic        pc_load;
    logic [15:0] pc_target;
    logic        squash;
    logic        halt;
    logic [15:0] pc_follow;
    logic [15:0] cnt;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model: architectural view of the stage.
  obs_t  m;
  bit    m_halted = 0;
  int    m_flush_left = 0;

  localparam logic [4:0] WRITERS [18] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05,
    5'h06, 5'h07, 5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h0F, 5'h11, 5'h12};
  localparam logic [4:0] OP_ADD = 5'h00, OP_MOV = 5'h08, OP_SUB = 5'h11, OP_STR = 5'h10,
                         OP_SYS = 5'h13, OP_NOP = 5'h14, OP_PRE = 5'h18;

  function automatic bit is_writer(input logic [4:0] op);
    foreach (WRITERS[k]) if (WRITERS[k] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit is_bubble(input logic [4:0] op);
    return (op == OP_NOP) || (op inside {[5'h15:5'h17]}) || (op[4:3] == 2'b11);
  endfunction

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [1:0] cc, input logic [3:0] rd);
    return {op, cc, 1'b0, rd, 4'h0};
  endfunction

  task automatic step(input logic rst_b, input logic [15:0] ir, input logic [15:0] res,
                      input logic [15:0] pcv, input string tag);
    logic [4:0] op;
    bit         fwd_exp;
    @(negedge clk);
    reset = rst_b; ir_in = ir; result = res; pc = pcv;
    op = ir[15:11];
    fwd_exp = rst_b && !m_halted && (m_flush_left == 0) && is_writer(op);
    if (!rst_b) begin
      m = '0; m_halted = 0; m_flush_left = 0;
    end else begin
      m.rf_we = 1'b0;
      m.pc_load = 1'b0;
      if (m_halted) begin
      end else if (m_flush_left > 0) begin
        m_flush_left--;
        m.squash = (m_flush_left != 0);
      end else if (!is_bubble(op)) begin
        m.pc_follow = pcv;
        m.cnt = m.cnt + 16'd1;
        if (ir[10:9] == 2'b01) m.z = (res == 16'h0);
        if (is_writer(op)) begin
          m.rf_we = 1'b1; m.rf_addr = ir[7:4]; m.rf_data = res;
          if (ir[7:4] == 4'hF) begin
            m.pc_load = 1'b1; m.pc_target = res; m.squash = 1'b1;
            m_flush_left = FLUSH_DEPTH;
          end
        end
        if (op == OP_SYS) begin
          m.halt = 1'b1; m_halted = 1;
        end
      end
    end
    exp_q.push_back(m);
    tag_q.push_back(tag);
`ifdef WB_FORWARD_EN
    #1;
    checks++;
    if (fwd_valid !== fwd_exp || (fwd_exp && (fwd_addr !== ir[7:4] || fwd_data !== res))) begin
      errors++;
      $display("FAIL fwd_%s: got v=%b a=%h d=%h want v=%b a=%h d=%h", tag, fwd_valid, fwd_addr,
               fwd_data, fwd_exp, ir[7:4], res);
    end
`else
    if (fwd_exp) begin end
`endif
  endtask

  // Monitor: compares every registered output snapshot against the scoreboard.
  always @(posedge clk) begin
    obs_t  act, e;
    string t;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      act = {rf_we, rf_addr, rf_data, z_out, pc_load, pc_target, squash, halt, pc_follow, retire_count};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got we=%b a=%h d=%h z=%b pl=%b pt=%h sq=%b h=%b pf=%h rc=%h want we=%b a=%h d=%h z=%b pl=%b pt=%h sq=%b h=%b pf=%h rc=%h",
                 t, act.rf_we, act.rf_addr, act.rf_data, act.z, act.pc_load, act.pc_target, act.squash,
                 act.halt, act.pc_follow, act.cnt, e.rf_we, e.rf_addr, e.rf_data, e.z, e.pc_load,
                 e.pc_target, e.squash, e.halt, e.pc_follow, e.cnt);
      end
    end
  end

  initial begin
    logic [4:0]  op;
    logic [3:0]  rd;
    logic [15:0] res;
    int          wait_cnt;
    m = '0;
    // Reset then basic commit.
    step(1'b0, 16'h0, 16'h0, 16'h0, "reset");
    step(1'b1, mk(OP_ADD, 2'b00, 4'd3), 16'h1234, 16'h0100, "add_commit");
    // Z flag behaviour.
    step(1'b1, mk(OP_SUB, 2'b01, 4'd1), 16'h0000, 16'h0102, "sub_s_zero");
    step(1'b1, mk(OP_MOV, 2'b01, 4'd2), 16'h0005, 16'h0104, "mov_s_nz");
    step(1'b1, mk(OP_SUB, 2'b01, 4'd1), 16'h0000, 16'h0106, "sub_s_zero2");
    step(1'b1, mk(OP_ADD, 2'b00, 4'd4), 16'h0000, 16'h0108, "add_al_hold");
    // Redirect and flush.
    step(1'b1, mk(OP_MOV, 2'b00, 4'hF), 16'h0040, 16'h010A, "mov_r15");
    for (int i = 0; i < 3; i++)
      step(1'b1, mk(OP_ADD, 2'b00, 4'd5), 16'h1111 + 16'(i), 16'h010C, "flush_discard");
    step(1'b1, mk(OP_ADD, 2'b00, 4'd6), 16'h2222, 16'h0040, "post_flush");
    // SYS and redirect inside a flush are discarded.
    step(1'b1, mk(OP_SUB, 2'b01, 4'hF), 16'h0000, 16'h0042, "r15_cc_s");
    step(1'b1, mk(OP_SYS, 2'b00, 4'd0), 16'h0000, 16'h0044, "sys_in_flush");
    step(1'b1, mk(OP_MOV, 2'b00, 4'hF), 16'h0080, 16'h0046, "r15_in_flush");
    step(1'b1, mk(OP_ADD, 2'b00, 4'd1), 16'h0001, 16'h0048, "flush_last");
    // Bubbles and STR.
    step(1'b1, mk(OP_NOP, 2'b01, 4'd1), 16'h0000, 16'h0200, "nop");
    step(1'b1, mk(OP_PRE, 2'b01, 4'd2), 16'h0000, 16'h0202, "pre");
    step(1'b1, mk(5'h16, 2'b01, 4'd2), 16'h0000, 16'h0203, "undef");
    step(1'b1, mk(OP_MOV, 2'b01, 4'd2), 16'h0009, 16'h0204, "mov_s_clear");
    step(1'b1, mk(OP_STR, 2'b01, 4'd3), 16'h0000, 16'h0206, "str_s_zero");
    // Halt.
    step(1'b1, mk(OP_SYS, 2'b00, 4'd0), 16'h0000, 16'h0300, "sys");
    step(1'b1, mk(OP_ADD, 2'b00, 4'd7), 16'h7777, 16'h0302, "halted_add");
    step(1'b1, mk(OP_MOV, 2'b01, 4'hF), 16'h0000, 16'h0304, "halted_r15");
    step(1'b0, 16'h0, 16'h0, 16'h0, "reset_halt");
    // Reset in the middle of a flush.
    step(1'b1, mk(OP_MOV, 2'b00, 4'hF), 16'h0010, 16'h0400, "r15_pre_reset");
    step(1'b0, mk(OP_ADD, 2'b00, 4'd1), 16'h0001, 16'h0402, "reset_mid_flush");
    step(1'b1, mk(OP_ADD, 2'b00, 4'd1), 16'h0003, 16'h0404, "after_mid_reset");
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (m_halted && $urandom_range(0, 3) == 0) begin
        step(1'b0, 16'h0, 16'h0, 16'h0, "rand_reset");
      end else begin
        op  = 5'($urandom_range(0, 31));
        rd  = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 15));
        res = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
        step($urandom_range(0, 99) != 0, {op, 2'($urandom_range(0, 3)), 1'b0, rd, 4'($urandom)},
             res, 16'($urandom), "random");
      end
    end
    // Retire counter wrap.
    step(1'b0, 16'h0, 16'h0, 16'h0, "reset_wrap");
    for (int i = 0; i < 65535; i++)
      step(1'b1, mk(OP_ADD, 2'b00, 4'd2), 16'(i), 16'(i), "count_up");
    step(1'b1, mk(OP_ADD, 2'b00, 4'd2), 16'hABCD, 16'hFFFE, "count_wrap");
    step(1'b1, mk(OP_STR, 2'b00, 4'd2), 16'h0000, 16'hFFFF, "count_after_wrap");
    // Drain with a bounded wait.
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
